cam_pixel_capture: RTL and testbench

Downstream consumer of the OV7670 SCCB configuration stage. It starts once camera init is complete.
It oversamples the camera parallel bus (pclk/vsync/href/d[7:0]) on clk_100MHz and pairs RGB565 bytes into 12-bit RGB444 pixels.
Each pixel goes out as a one-cycle write strobe with a linear frame-buffer address, ready for a dual-port BRAM feeding the VGA path.

---
 rtl/cam_pixel_capture.sv | 217 +++++++++++++++++++++
 tb/tb_cam_pixel_capture.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_capture.sv
// OV7670 parallel-bus capture: oversamples pclk/vsync/href/data on clk_100MHz, pairs RGB565
// bytes into RGB444 pixels and emits one-cycle frame-buffer writes at y*H_ACTIVE+x.
// Optional build macro CAM_CAPTURE_DECIMATE_EN stores only even pixels of even lines
// at (y>>1)*(H_ACTIVE/2)+(x>>1).
module cam_pixel_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk_100MHz,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [11:0]       pix_data,
  output logic              frame_done,
  output logic              line_ovf,
  output logic              busy
);

  localparam int unsigned XW = $clog2(H_ACTIVE + 1);
  localparam int unsigned YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] XMax = XW'(H_ACTIVE);
  localparam logic [YW-1:0] YMax = YW'(V_ACTIVE);
`ifdef CAM_CAPTURE_DECIMATE_EN
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(H_ACTIVE / 2);
`else
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(H_ACTIVE);
`endif

  typedef enum logic [1:0] {
    StWaitInit,
    StWaitFrame,
    StByte0,
    StByte1
  } state_e;

  // Synchroniser stages for the asynchronous camera bus
  logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic       vsync_s1_q, vsync_s2_q, vsync_s3_q;
  logic       href_s1_q, href_s2_q, href_s3_q;
  logic [7:0] data_s1_q, data_s2_q;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [6:0]        hi_q, hi_d;
  logic              pix_we_q, pix_we_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [11:0]       pix_data_q, pix_data_d;
  logic              frame_done_q, frame_done_d;
  logic              line_ovf_q, line_ovf_d;

  logic        pclk_rise, vsync_rise, vsync_fall, href_fall;
  logic        store_ok;
  logic [11:0] pixel;

  // Two-flop synchronisers plus a third stage on the edge-detected signals
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      pclk_s1_q  <= 1'b0;
      pclk_s2_q  <= 1'b0;
      pclk_s3_q  <= 1'b0;
      vsync_s1_q <= 1'b0;
      vsync_s2_q <= 1'b0;
      vsync_s3_q <= 1'b0;
      href_s1_q  <= 1'b0;
      href_s2_q  <= 1'b0;
      href_s3_q  <= 1'b0;
      data_s1_q  <= 8'h00;
      data_s2_q  <= 8'h00;
    end else begin
      pclk_s1_q  <= cam_pclk;
      pclk_s2_q  <= pclk_s1_q;
      pclk_s3_q  <= pclk_s2_q;
      vsync_s1_q <= cam_vsync;
      vsync_s2_q <= vsync_s1_q;
      vsync_s3_q <= vsync_s2_q;
      href_s1_q  <= cam_href;
      href_s2_q  <= href_s1_q;
      href_s3_q  <= href_s2_q;
      data_s1_q  <= cam_data;
      data_s2_q  <= data_s1_q;
    end
  end

  assign pclk_rise  = pclk_s2_q & ~pclk_s3_q;
  assign vsync_rise = vsync_s2_q & ~vsync_s3_q;
  assign vsync_fall = ~vsync_s2_q & vsync_s3_q;
  assign href_fall  = ~href_s2_q & href_s3_q;

  // RGB565 -> RGB444: keep the top bits of each channel
  assign pixel = {hi_q[6:3], hi_q[2:0], data_s2_q[7], data_s2_q[4:1]};

`ifdef CAM_CAPTURE_DECIMATE_EN
  assign store_ok = ~x_q[0] & ~y_q[0];
`else
  assign store_ok = 1'b1;
`endif

  // Capture FSM state and datapath registers
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StWaitInit;
      x_q          <= '0;
      y_q          <= '0;
      row_base_q   <= '0;
      hi_q         <= '0;
      pix_we_q     <= 1'b0;
      pix_addr_q   <= '0;
      pix_data_q   <= '0;
      frame_done_q <= 1'b0;
      line_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      row_base_q   <= row_base_d;
      hi_q         <= hi_d;
      pix_we_q     <= pix_we_d;
      pix_addr_q   <= pix_addr_d;
      pix_data_q   <= pix_data_d;
      frame_done_q <= frame_done_d;
      line_ovf_q   <= line_ovf_d;
    end
  end

  // Next-state: vsync_rise beats href_fall beats pclk_rise while capturing
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    row_base_d   = row_base_q;
    hi_d         = hi_q;
    pix_we_d     = 1'b0;
    pix_addr_d   = pix_addr_q;
    pix_data_d   = pix_data_q;
    frame_done_d = 1'b0;
    line_ovf_d   = line_ovf_q;

    if (!init_done) begin
      state_d    = StWaitInit;
      x_d        = '0;
      y_d        = '0;
      row_base_d = '0;
    end else begin
      unique case (state_q)
        StWaitInit: state_d = StWaitFrame;
        StWaitFrame: begin
          if (vsync_fall) begin
            state_d    = StByte0;
            x_d        = '0;
            y_d        = '0;
            row_base_d = '0;
          end
        end
        StByte0, StByte1: begin
          if (vsync_rise) begin
            frame_done_d = 1'b1;
            state_d      = StWaitFrame;
          end else if (href_fall) begin
            // Line end; an odd trailing byte is simply dropped
            state_d = StByte0;
            if (x_q != '0) begin
              x_d = '0;
              if (y_q < YMax) begin
                y_d = y_q + 1'b1;
`ifdef CAM_CAPTURE_DECIMATE_EN
                if (y_q[0]) row_base_d = row_base_q + RowStep;
`else
                row_base_d = row_base_q + RowStep;
`endif
              end else begin
                line_ovf_d = 1'b1;
              end
            end
          end else if (pclk_rise && href_s2_q) begin
            if (state_q == StByte0) begin
              hi_d    = {data_s2_q[7:4], data_s2_q[2:0]};
              state_d = StByte1;
            end else begin
              state_d = StByte0;
              if ((x_q < XMax) && (y_q < YMax)) begin
                x_d = x_q + 1'b1;
                if (store_ok) begin
                  pix_we_d   = 1'b1;
`ifdef CAM_CAPTURE_DECIMATE_EN
                  pix_addr_d = row_base_q + ADDR_W'(x_q >> 1);
`else
                  pix_addr_d = row_base_q + ADDR_W'(x_q);
`endif
                  pix_data_d = pixel;
                end
              end else begin
                line_ovf_d = 1'b1;
              end
            end
          end
        end
        default: state_d = StWaitInit;
      endcase
    end
  end

  assign pix_we     = pix_we_q;
  assign pix_addr   = pix_addr_q;
  assign pix_data   = pix_data_q;
  assign frame_done = frame_done_q;
  assign line_ovf   = line_ovf_q;
  assign busy       = (state_q == StByte0) || (state_q == StByte1);

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Self-checking bench for cam_pixel_capture: a reference model pushes expected writes to a
// scoreboard as camera bytes are driven; a negedge monitor pops and compares each pix_we.
module tb_cam_pixel_capture;

  localparam int unsigned H  = 640;
  localparam int unsigned V  = 480;
  localparam int unsigned AW = 19;
`ifdef CAM_CAPTURE_DECIMATE_EN
  localparam int unsigned ExpFrameWr = 640;
`else
  localparam int unsigned ExpFrameWr = 2560;
`endif

  logic          clk_100MHz = 1'b0;
  logic          rst_n      = 1'b0;
  logic          init_done  = 1'b0;
  logic          cam_pclk   = 1'b0;
  logic          cam_vsync  = 1'b1;
  logic          cam_href   = 1'b0;
  logic [7:0]    cam_data   = 8'h00;
  logic          pix_we;
  logic [AW-1:0] pix_addr;
  logic [11:0]   pix_data;
  logic          frame_done;
  logic          line_ovf;
  logic          busy;

  cam_pixel_capture #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .ADDR_W  (AW)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst_n     (rst_n),
    .init_done (init_done),
    .cam_pclk  (cam_pclk),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .pix_we    (pix_we),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .frame_done(frame_done),
    .line_ovf  (line_ovf),
    .busy      (busy)
  );

  initial forever #5 clk_100MHz = ~clk_100MHz;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [11:0]   data;
  } wr_t;

  wr_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: counts strobes and compares each write against the scoreboard head
  int            we_cnt = 0;
  int            fd_cnt = 0;
  bit            busy_seen = 1'b0;
  logic [AW-1:0] first_addr, last_addr;
  logic [11:0]   first_data;

  always @(negedge clk_100MHz) begin
    wr_t e;
    if (pix_we) begin
      if (we_cnt == 0) begin
        first_addr = pix_addr;
        first_data = pix_data;
      end
      last_addr = pix_addr;
      we_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_we", 32'(pix_we), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pix_addr", 32'(pix_addr), 32'(e.addr));
        check("pix_data", 32'(pix_data), 32'(e.data));
      end
    end
    if (frame_done) fd_cnt++;
    if (busy) busy_seen = 1'b1;
  end

  // Reference model state
  int mx = 0;
  int my = 0;
  bit m_cap = 1'b0;
  bit m_ovf = 1'b0;
  int exp_fd = 0;

  task automatic cam_byte(input logic [7:0] b);
    cam_data = b;
    #20 cam_pclk = 1'b1;
    #20 cam_pclk = 1'b0;
  endtask

  task automatic cam_pixel(input logic [7:0] hi, input logic [7:0] lo);
    wr_t e;
    bit  keep;
    cam_byte(hi);
    if (m_cap) begin
      if (mx < int'(H) && my < int'(V)) begin
`ifdef CAM_CAPTURE_DECIMATE_EN
        keep   = (mx % 2 == 0) && (my % 2 == 0);
        e.addr = AW'((my / 2) * int'(H / 2) + mx / 2);
`else
        keep   = 1'b1;
        e.addr = AW'(my * int'(H) + mx);
`endif
        e.data = {hi[7:4], hi[2:0], lo[7], lo[4:1]};
        if (keep) sb.push_back(e);
        mx++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    cam_byte(lo);
  endtask

  task automatic cam_line(input int npix, input bit rnd);
    cam_href = 1'b1;
    for (int i = 0; i < npix; i++) begin
      if (rnd) cam_pixel(8'($urandom), 8'($urandom));
      else     cam_pixel(8'hF8, 8'h1F);
    end
    cam_href = 1'b0;
    #80;
    if (m_cap && mx != 0) begin
      mx = 0;
      my++;
      if (my > int'(V)) m_ovf = 1'b1;
    end
  endtask

  task automatic vsync_rise();
    cam_vsync = 1'b1;
    if (m_cap) exp_fd++;
    m_cap = 1'b0;
    #200;
  endtask

  task automatic vsync_fall();
    cam_vsync = 1'b0;
    if (init_done) begin
      m_cap = 1'b1;
      mx    = 0;
      my    = 0;
    end
    #200;
  endtask

  initial begin
    // Reset values
    #23;
    check("rst_pix_we", 32'(pix_we), 32'd0);
    check("rst_pix_addr", 32'(pix_addr), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_line_ovf", 32'(line_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #7 rst_n = 1'b1;
    #100;

    // 1: no capture while init_done is low
    vsync_fall();
    cam_line(16, 1'b1);
    cam_line(16, 1'b1);
    vsync_rise();
    check("t1_we_cnt", 32'(we_cnt), 32'd0);
    check("t1_fd_cnt", 32'(fd_cnt), 32'd0);
    check("t1_busy_seen", 32'(busy_seen), 32'd0);

    // 2: full-width 4-line frame of pure red+blue
    init_done = 1'b1;
    #100;
    vsync_fall();
    check("t2_busy", 32'(busy), 32'd1);
    for (int l = 0; l < 4; l++) cam_line(int'(H), 1'b0);
    vsync_rise();
    check("t2_we_cnt", 32'(we_cnt), 32'(ExpFrameWr));
    check("t2_first_addr", 32'(first_addr), 32'd0);
    check("t2_first_data", 32'(first_data), 32'hF0F);
    check("t2_last_addr", 32'(last_addr), 32'(ExpFrameWr - 1));
    check("t2_fd_cnt", 32'(fd_cnt), 32'(exp_fd));
    check("t2_line_ovf", 32'(line_ovf), 32'(m_ovf));
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: over-long line sets the sticky overflow, next line starts at its own row
    vsync_fall();
    cam_line(int'(H) + 1, 1'b1);
    cam_line(8, 1'b1);
    vsync_rise();
    check("t3_line_ovf", 32'(line_ovf), 32'd1);
    check("t3_fd_cnt", 32'(fd_cnt), 32'(exp_fd));
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: capture enabled mid-frame waits for a fresh frame
    init_done = 1'b0;
    m_cap     = 1'b0;
    #100;
    check("t4_busy_off", 32'(busy), 32'd0);
    vsync_fall();
    cam_line(8, 1'b1);
    init_done = 1'b1;
    #100;
    cam_line(8, 1'b1);
    we_cnt = 0;
    vsync_rise();
    check("t4_we_mid", 32'(we_cnt), 32'd0);
    check("t4_fd_mid", 32'(fd_cnt), 32'(exp_fd));
    vsync_fall();
    cam_line(8, 1'b1);
    vsync_rise();
    check("t4_first_addr", 32'(first_addr), 32'd0);
    check("t4_fd_cnt", 32'(fd_cnt), 32'(exp_fd));
    check("t4_ovf_sticky", 32'(line_ovf), 32'd1);

    // 5: asynchronous reset mid-line
    vsync_fall();
    cam_href = 1'b1;
    for (int i = 0; i < 100; i++) cam_pixel(8'($urandom), 8'($urandom));
    #40;
    check("t5_pre_addr", 32'(pix_addr), 32'd99);
    rst_n = 1'b0;
    m_cap = 1'b0;
    m_ovf = 1'b0;
    #3;
    check("t5_rst_we", 32'(pix_we), 32'd0);
    check("t5_rst_addr", 32'(pix_addr), 32'd0);
    check("t5_rst_data", 32'(pix_data), 32'd0);
    check("t5_rst_ovf", 32'(line_ovf), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    #7 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cam_pixel(8'($urandom), 8'($urandom));
    cam_href = 1'b0;
    #80;
    we_cnt = 0;
    vsync_rise();
    vsync_fall();
    cam_line(4, 1'b1);
    vsync_rise();
    check("t5_first_addr", 32'(first_addr), 32'd0);
    check("t5_fd_cnt", 32'(fd_cnt), 32'(exp_fd));
    check("t5_line_ovf", 32'(line_ovf), 32'(m_ovf));

    check("end_sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
